wdt_timer: RTL and testbench
============================

# wdt_timer

Watchdog timer that generates the `timeout` signal consumed by the CPU's CSR unit, which treats it as the WDT reset and timer-interrupt source. Software programs it through a small memory-mapped register slave: enable, kick ("live"), and a timeout period. Once enabled, it counts core clock cycles and raises `timeout` when the period elapses without a kick. `timeout` then stays asserted until software kicks or disables the watchdog, or reset is applied.

## Interface
Parameters:
- `CNT_W`, 32, counter and period width; the read path zero-extends to 32 bits.

Ports:
- `clk`  in  1  core clock; the single clock for the block.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  register write strobe, one cycle per write.
- `rd_en`  in  1  register read strobe, one cycle per read.
- `addr`  in  12  register offset: 0x100 WDEN, 0x200 WDLIVE, 0x300 WTOCNT, 0x400 WDCNT (read-only).
- `wdata`  in  32  write data.
- `rdata`  out  32  registered read data.
- `rvalid`  out  1  high for one cycle, the cycle after `rd_en`.
- `timeout`  out  1  watchdog expired; level output to CSR `timeout`.

## Operation
- State machine: IDLE, COUNT, EXPIRED. Reset state is IDLE.
- Registers:
  - `wtocnt`: programmed period.
  - `period`: shadow of `wtocnt`, latched at each load.
  - `cnt`: current count.
  - `en`: mirrors WDEN bit0.
- A **load** means `cnt <= 0` and `period <= wtocnt`, both in the same edge.
- Write WDEN, `wdata[0]=1`:
  - From IDLE or COUNT: load, go to COUNT.
  - From EXPIRED: load, clear `timeout`, go to COUNT.
- Write WDEN, `wdata[0]=0`: go to IDLE from any state. `timeout` drops at the same edge; `cnt` holds its value.
- Write WDLIVE, `wdata[0]=1` (kick):
  - In COUNT or EXPIRED: load; EXPIRED returns to COUNT with `timeout` cleared.
  - In IDLE: ignored.
- Write WDLIVE with `wdata[0]=0`: ignored.
- Write WTOCNT: `wtocnt <= wdata[CNT_W-1:0]`. Takes effect only at the next load; a running count keeps comparing against `period`.
- In COUNT, with no register action this cycle:
  - If `cnt == period`: go to EXPIRED, `timeout <= 1`.
  - Otherwise `cnt <= cnt + 1`.
- In EXPIRED: `cnt` holds and `timeout` stays 1 until a kick, a disable, or reset.
- Write to 0x400 or any unmapped offset: ignored.
- Reads return:
  - WDEN: `{31'b0, en}`.
  - WDLIVE: 0.
  - WTOCNT: `wtocnt`.
  - WDCNT: `cnt`.
  - Unmapped offsets: 0.
- `wr_en` and `rd_en` in the same cycle: the write is performed. The read returns the pre-write value, with `rvalid` as normal.

## Timing
- Reset values:
  - Outputs: `timeout=0`, `rdata=0`, `rvalid=0`.
  - State: IDLE.
  - Registers: `cnt=0`, `period=0`, `wtocnt=0`, `en=0`.
  - Reset mid-count or while EXPIRED clears everything immediately (asynchronous) and drops `timeout` without waiting for a clock edge.
- Expiry latency:
  - The enable write is sampled at edge E, so `cnt=0` in the cycle after E.
  - `timeout` rises at edge E+N+1 for `period=N`. That is N+1 counting cycles.
  - N=0 gives `timeout` at E+1.
- Kick latency: a kick sampled at edge K restarts the count, so the next expiry is at K+N+1.
- Simultaneous events, decided against the same-cycle expiry compare:
  - Disable in the same cycle as `cnt==period`: disable wins, `timeout` stays 0.
  - Kick in the same cycle as `cnt==period`: kick wins, reload, no expiry.
- Wrap-around: none. `cnt` stops at `period`, and `period <= 2^CNT_W-1` guarantees no overflow.
- Read latency: exactly 1 cycle. `rdata` holds its last value when `rvalid=0`.
- `timeout` is a registered output with no combinational path from inputs. It changes only at clock edges, or asynchronously on reset.

## Test plan
- **Basic expiry:** WTOCNT=5, WDEN=1 at edge E -> `timeout` 0 through E+5, 1 at E+6 and held; WDCNT reads 5.
- **Periodic kick:** WTOCNT=10, WDEN=1, kick every 8 cycles for 100 cycles -> `timeout` never asserts; stop kicking -> `timeout` exactly 11 cycles after the last kick.
- **Recovery from EXPIRED:** from EXPIRED, kick -> `timeout` falls next edge, state COUNT, `cnt=0`; then write WDEN=0 -> IDLE, kicks ignored, `timeout` stays 0.
- **Shadow period:** WTOCNT=20, enable, at `cnt=3` write WTOCNT=2 -> expiry still at count 20; next kick uses 2 (`timeout` 3 cycles after the kick).
- **Boundary collisions:** WTOCNT=0 -> `timeout` 1 cycle after enable. WDEN=0 written in the `cnt==period` cycle -> `timeout` stays 0. Kick in the `cnt==period` cycle -> no expiry.
- **Reset and reads:** assert `rst` while EXPIRED -> `timeout` drops immediately, and all reads return 0 after release. `rd_en` to 0x300 with simultaneous write of 7 -> `rvalid` next cycle with the old value, and a subsequent read returns 7.

Source files
------------

// File: rtl/wdt_timer.sv
// wdt_timer: watchdog timer with a memory-mapped register slave.
// Ports: clk/rst (async active-high); wr_en/rd_en register strobes; addr register offset
// (0x100 WDEN, 0x200 WDLIVE, 0x300 WTOCNT, 0x400 WDCNT); wdata write data; rdata/rvalid
// registered read response one cycle after rd_en; timeout level output while expired.
module wdt_timer #(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [11:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        timeout
);
    typedef enum logic [1:0] {IDLE, COUNT, EXPIRED} state_t;

    localparam logic [11:0] A_WDEN   = 12'h100;
    localparam logic [11:0] A_WDLIVE = 12'h200;
    localparam logic [11:0] A_WTOCNT = 12'h300;
    localparam logic [11:0] A_WDCNT  = 12'h400;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, period_q, period_d, wtocnt_q, wtocnt_d;
    logic               en_q, en_d, timeout_q, timeout_d, rvalid_q, rvalid_d;
    logic [31:0]        rdata_q, rdata_d, rd_mux;
    logic               wr_den, kick;

    assign wr_den = wr_en && addr == A_WDEN;
    assign kick   = wr_en && addr == A_WDLIVE && wdata[0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        en_d      = en_q;
        timeout_d = timeout_q;
        wtocnt_d  = (wr_en && addr == A_WTOCNT) ? wdata[CNT_W-1:0] : wtocnt_q;
        if (wr_den) begin
            en_d      = wdata[0];
            timeout_d = 1'b0;
            state_d   = wdata[0] ? COUNT : IDLE;
            if (wdata[0]) begin
                cnt_d    = '0;
                period_d = wtocnt_q;
            end
        end else if (kick && state_q != IDLE) begin
            cnt_d     = '0;
            period_d  = wtocnt_q;
            timeout_d = 1'b0;
            state_d   = COUNT;
        end else if (state_q == COUNT) begin
            // Expiry compare only runs when no enable/kick claims this cycle.
            if (cnt_q == period_q) begin
                state_d   = EXPIRED;
                timeout_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Reads see pre-write register values so a same-cycle write does not leak through.
    always_comb begin
        rd_mux   = addr == A_WDEN   ? {31'b0, en_q} :
                   addr == A_WTOCNT ? 32'(wtocnt_q) :
                   addr == A_WDCNT  ? 32'(cnt_q)    : 32'b0;
        rvalid_d = rd_en;
        rdata_d  = rd_en ? rd_mux : rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            wtocnt_q  <= '0;
            en_q      <= 1'b0;
            timeout_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            wtocnt_q  <= wtocnt_d;
            en_q      <= en_d;
            timeout_q <= timeout_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    assign timeout = timeout_q;
    assign rdata   = rdata_q;
    assign rvalid  = rvalid_q;
endmodule

// File: tb/tb_wdt_timer.sv
// tb_wdt_timer: directed self-checking bench for wdt_timer.
// Ports: none; drives and samples the DUT on the falling clock edge.
module tb_wdt_timer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [11:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        rvalid;
    logic        timeout;
    int          nvec = 0;
    int          nerr = 0;

    wdt_timer #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
        .wdata(wdata), .rdata(rdata), .rvalid(rvalid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Called at a falling edge; the write is sampled at the following rising edge,
    // and the task returns at the falling edge right after it.
    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] d, output logic v);
        addr = a; rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        d = rdata; v = rvalid;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic v;
        nvec++; if (timeout !== 1'b0) begin nerr++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
        nvec++; if (rdata !== 32'h0) begin nerr++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        nvec++; if (rvalid !== 1'b0) begin nerr++; $display("FAIL reset_rvalid got=%b exp=0", rvalid); end
        @(negedge clk); rst = 1'b0; @(negedge clk);
        rd(12'h400, d, v);
        nvec++; if (d !== 32'h0 || v !== 1'b1) begin nerr++; $display("FAIL reset_wdcnt got=%h/%b exp=0/1", d, v); end
        rd(12'h100, d, v);
        nvec++; if (d !== 32'h0) begin nerr++; $display("FAIL reset_wden got=%h exp=0", d); end
    endtask

    task automatic test_basic_expiry();
        logic [31:0] d; logic v;
        wr(12'h300, 5);
        wr(12'h100, 1);
        for (int i = 0; i <= 5; i++) begin
            nvec++; if (timeout !== 1'b0) begin nerr++; $display("FAIL basic_early E+%0d got=%b exp=0", i, timeout); end
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            nvec++; if (timeout !== 1'b1) begin nerr++; $display("FAIL basic_held +%0d got=%b exp=1", i, timeout); end
            @(negedge clk);
        end
        rd(12'h400, d, v);
        nvec++; if (d !== 32'd5) begin nerr++; $display("FAIL basic_wdcnt got=%0d exp=5", d); end
        rd(12'h100, d, v);
        nvec++; if (d !== 32'd1) begin nerr++; $display("FAIL basic_wden got=%0d exp=1", d); end
        rd(12'h200, d, v);
        nvec++; if (d !== 32'd0) begin nerr++; $display("FAIL basic_wdlive got=%0d exp=0", d); end
    endtask

    task automatic test_periodic_kick();
        wr(12'h300, 10);
        wr(12'h100, 1);
        for (int k = 0; k < 12; k++) begin
            wr(12'h200, 1);
            for (int i = 0; i < 7; i++) begin
                nvec++; if (timeout !== 1'b0) begin nerr++; $display("FAIL kick_loop k=%0d i=%0d got=%b exp=0", k, i, timeout); end
                @(negedge clk);
            end
        end
        wr(12'h200, 1);
        for (int i = 0; i <= 10; i++) begin
            nvec++; if (timeout !== 1'b0) begin nerr++; $display("FAIL kick_tail K+%0d got=%b exp=0", i, timeout); end
            @(negedge clk);
        end
        nvec++; if (timeout !== 1'b1) begin nerr++; $display("FAIL kick_expire K+11 got=%b exp=1", timeout); end
    endtask

    task automatic test_recovery();
        logic [31:0] d; logic v;
        wr(12'h200, 1);
        nvec++; if (timeout !== 1'b0) begin nerr++; $display("FAIL recov_kick got=%b exp=0", timeout); end
        rd(12'h400, d, v);
        nvec++; if (d !== 32'd0) begin nerr++; $display("FAIL recov_cnt got=%0d exp=0", d); end
        wr(12'h100, 0);
        nvec++; if (timeout !== 1'b0) begin nerr++; $display("FAIL recov_dis got=%b exp=0", timeout); end
        wr(12'h200, 1);
        for (int i = 0; i < 15; i++) begin
            nvec++; if (timeout !== 1'b0) begin nerr++; $display("FAIL recov_idle i=%0d got=%b exp=0", i, timeout); end
            @(negedge clk);
        end
        rd(12'h400, d, v);
        nvec++; if (d !== 32'd1) begin nerr++; $display("FAIL recov_cnt_hold got=%0d exp=1", d); end
        rd(12'h100, d, v);
        nvec++; if (d !== 32'd0) begin nerr++; $display("FAIL recov_wden got=%0d exp=0", d); end
    endtask

    task automatic test_shadow_period();
        wr(12'h300, 20);
        wr(12'h100, 1);
        repeat (3) @(negedge clk);
        wr(12'h300, 2);
        for (int i = 4; i <= 20; i++) begin
            nvec++; if (timeout !== 1'b0) begin nerr++; $display("FAIL shadow_early E+%0d got=%b exp=0", i, timeout); end
            @(negedge clk);
        end
        nvec++; if (timeout !== 1'b1) begin nerr++; $display("FAIL shadow_expire E+21 got=%b exp=1", timeout); end
        wr(12'h200, 1);
        for (int i = 0; i <= 2; i++) begin
            nvec++; if (timeout !== 1'b0) begin nerr++; $display("FAIL shadow_kick K+%0d got=%b exp=0", i, timeout); end
            @(negedge clk);
        end
        nvec++; if (timeout !== 1'b1) begin nerr++; $display("FAIL shadow_new K+3 got=%b exp=1", timeout); end
    endtask

    task automatic test_collisions();
        logic [31:0] d; logic v;
        wr(12'h300, 0);
        wr(12'h100, 1);
        nvec++; if (timeout !== 1'b0) begin nerr++; $display("FAIL zero_E got=%b exp=0", timeout); end
        @(negedge clk);
        nvec++; if (timeout !== 1'b1) begin nerr++; $display("FAIL zero_E+1 got=%b exp=1", timeout); end
        wr(12'h100, 0);
        wr(12'h300, 3);
        wr(12'h100, 1);
        repeat (3) @(negedge clk);
        wr(12'h100, 0);
        for (int i = 0; i < 5; i++) begin
            nvec++; if (timeout !== 1'b0) begin nerr++; $display("FAIL dis_collide i=%0d got=%b exp=0", i, timeout); end
            @(negedge clk);
        end
        rd(12'h400, d, v);
        nvec++; if (d !== 32'd3) begin nerr++; $display("FAIL dis_cnt got=%0d exp=3", d); end
        wr(12'h100, 1);
        repeat (3) @(negedge clk);
        wr(12'h200, 1);
        for (int i = 0; i <= 3; i++) begin
            nvec++; if (timeout !== 1'b0) begin nerr++; $display("FAIL kick_collide K+%0d got=%b exp=0", i, timeout); end
            @(negedge clk);
        end
        nvec++; if (timeout !== 1'b1) begin nerr++; $display("FAIL kick_collide K+4 got=%b exp=1", timeout); end
        wr(12'h200, 0);
        wr(12'h400, 32'h55);
        nvec++; if (timeout !== 1'b1) begin nerr++; $display("FAIL ignored_writes got=%b exp=1", timeout); end
    endtask

    task automatic test_reset_and_reads();
        logic [31:0] d; logic v;
        nvec++; if (timeout !== 1'b1) begin nerr++; $display("FAIL pre_rst got=%b exp=1", timeout); end
        #2 rst = 1'b1;
        #1;
        nvec++; if (timeout !== 1'b0) begin nerr++; $display("FAIL async_rst got=%b exp=0", timeout); end
        @(negedge clk); rst = 1'b0; @(negedge clk);
        for (int a = 1; a <= 5; a++) begin
            rd(12'(a * 256), d, v);
            nvec++; if (d !== 32'h0 || v !== 1'b1) begin nerr++; $display("FAIL post_rst a=%0h got=%h/%b exp=0/1", a * 256, d, v); end
        end
        wr(12'h300, 9);
        addr = 12'h300; wdata = 7; wr_en = 1'b1; rd_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
        nvec++; if (rvalid !== 1'b1 || rdata !== 32'd9) begin nerr++; $display("FAIL rw_same got=%0d/%b exp=9/1", rdata, rvalid); end
        rd(12'h300, d, v);
        nvec++; if (d !== 32'd7) begin nerr++; $display("FAIL rw_after got=%0d exp=7", d); end
        @(negedge clk);
        nvec++; if (rvalid !== 1'b0 || rdata !== 32'd7) begin nerr++; $display("FAIL rdata_hold got=%0d/%b exp=7/0", rdata, rvalid); end
        wr(12'h300, 32'hFFFF_FFFF);
        rd(12'h300, d, v);
        nvec++; if (d !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL wtocnt_max got=%h exp=ffffffff", d); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic_expiry();
        wr(12'h100, 0);
        test_periodic_kick();
        test_recovery();
        test_shadow_period();
        wr(12'h100, 0);
        test_collisions();
        test_reset_and_reads();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
